// File: rtl/present_pkg.sv
// Shared PRESENT constants: widths, round count, S-box table and key-schedule FSM states.
// The S-box table is shared with the round S-layer.
package present_pkg;

    localparam int KEY_W      = 80;
    localparam int STATE_W    = 64;
    localparam int NUM_ROUNDS = 32;

    // Entry [n] is S(n); the packed list is written from entry 15 down to entry 0.
    localparam logic [15:0][3:0] SBOX_TBL = {
        4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
        4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
    };

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ks_state_t;

endpackage

// File: rtl/present_sbox.sv
// PRESENT 4-bit S-box lookup, purely combinational.
// Zero latency, no flow control.
module present_sbox
    import present_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = SBOX_TBL[i_nib];

endmodule

// File: rtl/present_key_schedule.sv
// Iterative PRESENT-80 key schedule: loads a user key, then streams K1..K(NUM_RK) over valid/ready.
// Load-to-first-key is 1 cycle; a stalled key holds rk/rk_idx until rk_ready, and done pulses after the last transfer.
module present_key_schedule
    import present_pkg::*;
#(
    parameter int NUM_RK = NUM_ROUNDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [KEY_W-1:0] ld_key,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk,
    output logic [4:0]       rk_idx,
    output logic             done
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_RK - 1);

    ks_state_t        r_state;
    ks_state_t        w_state_nxt;
    logic [KEY_W-1:0] r_key;
    logic [4:0]       r_idx;
    logic             r_done;

    logic             w_load;
    logic             w_xfer;
    logic             w_last;
    logic [KEY_W-1:0] w_rot;
    logic [3:0]       w_sb_out;
    logic [4:0]       w_cnt;
    logic [KEY_W-1:0] w_key_upd;

    // Round-key update: rotate left 61, S-box the top nibble, fold the round counter into bits 19:15.
    assign w_rot = {r_key[18:0], r_key[79:19]};
    assign w_cnt = r_idx + 5'd1;

    present_sbox u_sbox (
        .i_nib (w_rot[79:76]),
        .o_nib (w_sb_out)
    );

    assign w_key_upd = {w_sb_out, w_rot[75:20], w_rot[19:15] ^ w_cnt, w_rot[14:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ld_ready    = 1'b0;
        w_load      = 1'b0;
        w_xfer      = 1'b0;
        w_last      = (r_idx == LAST_IDX);
        case (r_state)
            IDLE: begin
                ld_ready = 1'b1;
                w_load   = ld_valid;
                if (ld_valid) begin
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                w_xfer = rk_ready;
                if (rk_ready && w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key  <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_xfer & w_last;
            if (w_load) begin
                r_key <= ld_key;
                r_idx <= '0;
            end else if (w_xfer && !w_last) begin
                r_key <= w_key_upd;
                r_idx <= w_cnt;
            end
        end
    end

    // The final key stays in r_key after the stream ends; rk_valid alone marks it stale.
    assign rk_valid = (r_state == EMIT);
    assign rk       = r_key;
    assign rk_idx   = r_idx;
    assign done     = r_done;

endmodule

// File: tb/tb_present_key_schedule.sv
// Directed bench for present_key_schedule: zero-key vectors, backpressure, load-in-EMIT, async reset,
// known-answer ciphertext through a PRESENT round model, random keys, and a NUM_RK=2 instance.
module tb_present_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid, ld_ready, rk_valid, rk_ready, done;
    logic [79:0] ld_key, rk;
    logic [4:0]  rk_idx;
    logic        ld_valid2, ld_ready2, rk_valid2, rk_ready2, done2;
    logic [79:0] ld_key2, rk2;
    logic [4:0]  rk_idx2;

    int n_cmp = 0;
    int n_err = 0;

    logic [79:0] cap [32];
    logic [3:0]  sb_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    localparam logic [79:0] K2_ZERO = 80'hC000_0000_0000_0000_8000;
    localparam logic [79:0] K3_ZERO = 80'h5000_1800_0000_0001_0000;

    present_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_key   (ld_key),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .done     (done)
    );

    present_key_schedule #(.NUM_RK(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_valid (ld_valid2),
        .ld_ready (ld_ready2),
        .ld_key   (ld_key2),
        .rk_valid (rk_valid2),
        .rk_ready (rk_ready2),
        .rk       (rk2),
        .rk_idx   (rk_idx2),
        .done     (done2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] ref_upd(input logic [79:0] k, input int c);
        logic [79:0] t;
        logic [4:0]  c5;
        c5 = c[4:0];
        t = (k << 61) | (k >> 19);
        t[79:76] = sb_t[t[79:76]];
        t[19:15] = t[19:15] ^ c5;
        return t;
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] pt);
        logic [63:0] st, s, p;
        st = pt;
        for (int r = 0; r < 31; r++) begin
            st = st ^ cap[r][79:16];
            for (int n = 0; n < 16; n++) s[n*4 +: 4] = sb_t[st[n*4 +: 4]];
            for (int b = 0; b < 64; b++) p[(b == 63) ? 63 : (b * 16) % 63] = s[b];
            st = p;
        end
        return st ^ cap[31][79:16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high; mode 1: ready 1,0,0,1 pattern; mode 2: ld_valid all-ones from idx 5 on.
    task automatic stream(input string tag, input logic [79:0] key, input int mode);
        logic [79:0] exp_k;
        int idx = 0;
        int cyc = 0;
        chk({tag, "_ld_ready_idle"}, 80'(ld_ready), 80'd1);
        ld_key   = key;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        exp_k    = key;
        while (idx < 32 && cyc < 200) begin
            rk_ready = (mode == 1) ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if (mode == 2 && idx == 5) begin
                ld_valid = 1'b1;
                ld_key   = '1;
            end
            chk({tag, "_rk_valid"}, 80'(rk_valid), 80'd1);
            chk({tag, "_rk"}, rk, exp_k);
            chk({tag, "_rk_idx"}, 80'(rk_idx), 80'(idx));
            if (mode == 2) chk({tag, "_ld_ready_emit"}, 80'(ld_ready), 80'd0);
            if (rk_ready) begin
                cap[idx] = rk;
                idx++;
                exp_k = ref_upd(exp_k, idx);
            end
            tick();
            cyc++;
        end
        chk({tag, "_xfer_count"}, 80'(idx), 80'd32);
        chk({tag, "_done_pulse"}, 80'(done), 80'd1);
        chk({tag, "_ld_ready_done"}, 80'(ld_ready), 80'd1);
        chk({tag, "_rk_valid_done"}, 80'(rk_valid), 80'd0);
        chk({tag, "_rk_hold"}, rk, cap[31]);
        tick();
        ld_valid = 1'b0;
        chk({tag, "_done_low"}, 80'(done), 80'd0);
        if (mode == 2) begin
            chk({tag, "_new_load_valid"}, 80'(rk_valid), 80'd1);
            chk({tag, "_new_load_rk"}, rk, {80{1'b1}});
            chk({tag, "_new_load_idx"}, 80'(rk_idx), 80'd0);
        end
    endtask

    initial begin
        int nx, mx, nd;
        rst_n     = 1'b0;
        ld_valid  = 1'b0;
        ld_key    = '0;
        rk_ready  = 1'b1;
        ld_valid2 = 1'b0;
        ld_key2   = '0;
        rk_ready2 = 1'b1;
        #12;
        chk("rst_rk", rk, 80'd0);
        chk("rst_rk_idx", 80'(rk_idx), 80'd0);
        chk("rst_rk_valid", 80'(rk_valid), 80'd0);
        chk("rst_done", 80'(done), 80'd0);
        chk("rst_ld_ready", 80'(ld_ready), 80'd1);
        rst_n = 1'b1;
        tick();

        stream("zero", 80'd0, 0);
        chk("zero_K1", cap[0], 80'd0);
        chk("zero_K2", cap[1], K2_ZERO);
        chk("zero_K3", cap[2], K3_ZERO);
        chk("zero_K3_upper", 80'(cap[2][79:16]), 80'h5000180000000001);
        chk("kat_ciphertext", 80'(encrypt(64'd0)), 80'h5579C1387B228445);

        stream("bp", 80'd0, 1);
        chk("bp_K3", cap[2], K3_ZERO);

        stream("ldemit", 80'd0, 2);

        // async reset while the all-ones stream is in flight
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rk_valid", 80'(rk_valid), 80'd0);
        chk("arst_rk", rk, 80'd0);
        chk("arst_ld_ready", 80'(ld_ready), 80'd1);
        #2 rst_n = 1'b1;
        tick();

        // stream to idx 10, then reset asynchronously mid-cycle
        ld_key = '0;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 10 && rk_idx != 5'd10; i++) tick();
        chk("mid_idx10", 80'(rk_idx), 80'd10);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_rk_valid", 80'(rk_valid), 80'd0);
        chk("mid_rst_rk", rk, 80'd0);
        chk("mid_rst_ld_ready", 80'(ld_ready), 80'd1);
        chk("mid_rst_idx", 80'(rk_idx), 80'd0);
        #2 rst_n = 1'b1;
        tick();
        stream("restart", 80'd0, 0);
        chk("restart_K2", cap[1], K2_ZERO);

        for (int t = 0; t < 3; t++) begin
            stream("rand", {$urandom(), $urandom(), 16'($urandom())}, t % 2);
        end

        // NUM_RK = 2 instance
        chk("nrk2_ld_ready", 80'(ld_ready2), 80'd1);
        ld_valid2 = 1'b1;
        tick();
        ld_valid2 = 1'b0;
        nx = 0;
        mx = 0;
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            if (done2) nd++;
            if (rk_valid2 && rk_ready2) begin
                nx++;
                if (int'(rk_idx2) > mx) mx = int'(rk_idx2);
                if (nx == 2) chk("nrk2_K2", rk2, K2_ZERO);
            end
            tick();
        end
        chk("nrk2_xfers", 80'(nx), 80'd2);
        chk("nrk2_max_idx", 80'(mx), 80'd1);
        chk("nrk2_done_count", 80'(nd), 80'd1);
        chk("nrk2_idle", 80'(ld_ready2), 80'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
